// File: rtl/tx_scheduler_pkg.sv
// tx_scheduler_pkg: shared FSM state and grant-source encodings.
package tx_scheduler_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START     = 2'b01,
    WAIT_ACK  = 2'b10,
    WAIT_DONE = 2'b11
  } state_e;
  typedef enum logic {
    GRANT_FIFO = 1'b0,
    GRANT_DBG  = 1'b1
  } grant_e;
endpackage

// File: rtl/tx_scheduler_if.sv
// tx_scheduler_if: core byte stream, debug requester, UART handshake and status.
interface tx_scheduler_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W = 16
);
  logic                  push;
  logic [7:0]            push_data;
  logic                  dbg_req;
  logic [7:0]            dbg_data;
  logic                  dbg_ack;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_busy;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [CNT_W-1:0]      sent_count;
  modport master (
    output push, push_data, dbg_req, dbg_data, tx_busy,
    input  dbg_ack, tx_start, tx_data, fifo_count, full, empty, overflow, sent_count
  );
  modport slave (
    input  push, push_data, dbg_req, dbg_data, tx_busy,
    output dbg_ack, tx_start, tx_data, fifo_count, full, empty, overflow, sent_count
  );
endinterface

// File: rtl/tx_scheduler_sync_fifo.sv
// sync_fifo: circular byte buffer; a pop frees its slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_pop, do_push;
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_d    = rd_q + DEPTH_LOG2'(do_pop);
    wr_d    = wr_q + DEPTH_LOG2'(do_push);
    count_d = count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  assign dout  = mem_q[rd_q];
  assign count = count_q;
  assign full  = count_q == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: buffers core bytes and round-robins them with debug bytes onto one UART.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  tx_scheduler_if.slave bus
);
  state_e              state_q, state_d;
  grant_e              last_q, last_d;
  logic [7:0]          data_q, data_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [7:0]          head;
  logic [DEPTH_LOG2:0] count;
  logic                full, empty, grant, pick_dbg, pop;
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk), .rst(rst), .push(bus.push), .pop(pop), .din(bus.push_data),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    grant    = state_q == IDLE && !bus.tx_busy && (bus.dbg_req || !empty);
    pick_dbg = bus.dbg_req && (empty || last_q == GRANT_FIFO);
    pop      = grant && !pick_dbg;
    state_d  = state_q == IDLE     ? (grant ? START : IDLE) :
               state_q == START    ? WAIT_ACK :
               state_q == WAIT_ACK ? (bus.tx_busy ? WAIT_DONE : WAIT_ACK) :
                                     (bus.tx_busy ? WAIT_DONE : IDLE);
    last_d   = grant ? (pick_dbg ? GRANT_DBG : GRANT_FIFO) : last_q;
    data_d   = grant ? (pick_dbg ? bus.dbg_data : head) : data_q;
    ovf_d    = ovf_q || (bus.push && full && !pop);
    sent_d   = sent_q + CNT_W'(state_q == START);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_FIFO;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      sent_q  <= sent_d;
    end
  end
  assign bus.tx_start   = state_q == START;
  assign bus.dbg_ack    = state_q == START && last_q == GRANT_DBG;
  assign bus.tx_data    = data_q;
  assign bus.fifo_count = count;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = ovf_q;
  assign bus.sent_count = sent_q;
endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed scenarios plus random traffic against a queue-based scheduler model.
module tb_tx_scheduler;
  import tx_scheduler_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tx_scheduler_if #(.DEPTH_LOG2(4), .CNT_W(16)) w ();
  tx_scheduler_if #(.DEPTH_LOG2(2), .CNT_W(2))  s ();
  tx_scheduler #(.DEPTH_LOG2(4), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(w.slave));
  tx_scheduler #(.DEPTH_LOG2(2), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(s.slave));
  int frame = 4;
  int bcnt = 0, bcnt_s = 0;
  always @(posedge clk) bcnt <= w.tx_start ? frame : (bcnt != 0 ? bcnt - 1 : 0);
  always @(posedge clk) bcnt_s <= s.tx_start ? 2 : (bcnt_s != 0 ? bcnt_s - 1 : 0);
  assign w.tx_busy = bcnt != 0;
  assign s.tx_busy = bcnt_s != 0;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: a byte queue plus "free" flag for when the scheduler may next grant.
  logic [7:0]  q[$];
  logic [7:0]  sent_log[$];
  int          ack_n = 0;
  bit          chk_on = 0;
  logic        m_ovf = 0, m_start = 0, m_dbg = 0, m_free = 1, m_rose = 0;
  logic [15:0] m_sent = 0;
  logic [7:0]  m_data = 0;
  grant_e      m_last = GRANT_FIFO;
  always @(negedge clk) begin
    logic g, pick;
    logic [7:0] hd;
    if (chk_on) begin
      chk("tx_start", w.tx_start, m_start);
      if (m_start) chk("tx_data", w.tx_data, m_data);
      chk("dbg_ack", w.dbg_ack, m_start && m_dbg);
      chk("fifo_count", w.fifo_count, q.size());
      chk("full", w.full, q.size() == DEPTH);
      chk("empty", w.empty, q.size() == 0);
      chk("overflow", w.overflow, m_ovf);
      chk("sent_count", w.sent_count, m_sent);
    end
    if (w.tx_start) sent_log.push_back(w.tx_data);
    if (w.dbg_ack) ack_n++;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_sent = 0; m_last = GRANT_FIFO; m_start = 0; m_free = 1; m_rose = 0;
    end else begin
      g    = m_free && !w.tx_busy && (w.dbg_req || q.size() != 0);
      pick = w.dbg_req && (q.size() == 0 || m_last == GRANT_FIFO);
      hd   = 8'h00;
      if (g && !pick) hd = q.pop_front();
      if (w.push) begin
        if (q.size() < DEPTH) q.push_back(w.push_data);
        else m_ovf = 1;
      end
      if (m_start) m_sent = m_sent + 16'd1;
      if (!m_free && !m_start) begin
        if (w.tx_busy) m_rose = 1;
        else if (m_rose) m_free = 1;
      end
      if (g) begin
        m_free = 0; m_rose = 0;
        m_last = pick ? GRANT_DBG : GRANT_FIFO;
        m_data = pick ? w.dbg_data : hd;
      end
      m_dbg   = pick;
      m_start = g;
    end
  end
  task automatic step();
    logic a;
    a = w.dbg_ack;
    @(posedge clk);
    #1;
    if (a) w.dbg_req = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic wait_start(input string nm, input int bound, output int n);
    n = 0;
    while (!w.tx_start && n < bound) begin
      step();
      n++;
    end
    chk(nm, w.tx_start, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    w.push = 0; w.push_data = 0; w.dbg_req = 0; w.dbg_data = 0;
    s.push = 0; s.push_data = 0; s.dbg_req = 0; s.dbg_data = 0;
    frame = 88;
    step();
    chk_on = 1;
    step();
    rst = 1'b0;
    chk("rst_tx_start", w.tx_start, 0);
    chk("rst_dbg_ack", w.dbg_ack, 0);
    chk("rst_tx_data", w.tx_data, 0);
    chk("rst_count", w.fifo_count, 0);
    chk("rst_empty", w.empty, 1);
    chk("rst_full", w.full, 0);
    chk("rst_overflow", w.overflow, 0);
    chk("rst_sent", w.sent_count, 0);
    // Latency: push in cycle 10 starts the UART in cycle 12; busy 13..100.
    repeat (10) step();
    w.push = 1; w.push_data = 8'h41;
    step();
    w.push = 0;
    chk("t1_c11_start", w.tx_start, 0);
    step();
    chk("t1_start", w.tx_start, 1);
    chk("t1_data", w.tx_data, 8'h41);
    step();
    chk("t1_sent", w.sent_count, 1);
    w.push = 1; w.push_data = 8'h42;
    step();
    w.push = 0;
    wait_start("t1_next", 300, n);
    chk("t1_gap", (14 + n) >= 102, 1);
    // Push and pop together while full.
    do_reset();
    frame = 40;
    w.push = 1; w.push_data = 8'hA0;
    step();
    w.push = 0;
    wait_start("t4_first", 200, n);
    step();
    for (int i = 0; i < 16; i++) begin
      w.push = 1; w.push_data = 8'hB0 + 8'(i);
      step();
    end
    w.push = 0;
    chk("t4_count16", w.fifo_count, 16);
    chk("t4_full", w.full, 1);
    n = 0;
    while (w.tx_busy && n < 100) begin step(); n++; end
    chk("t4_busy_fell", w.tx_busy, 0);
    step();
    w.push = 1; w.push_data = 8'hC0;
    chk("t4_full_pre", w.full, 1);
    step();
    w.push = 0;
    chk("t4_start", w.tx_start, 1);
    chk("t4_data", w.tx_data, 8'hB0);
    chk("t4_count", w.fifo_count, 16);
    chk("t4_ovf", w.overflow, 0);
    // Overflow: 20 bytes into a 16-deep FIFO while the UART is busy.
    do_reset();
    frame = 40;
    w.push = 1; w.push_data = 8'hAA;
    step();
    w.push = 0;
    wait_start("t2_first", 200, n);
    step();
    for (int i = 0; i < 20; i++) begin
      w.push = 1; w.push_data = 8'(i);
      step();
    end
    w.push = 0;
    frame = 3;
    chk("t2_full", w.full, 1);
    chk("t2_ovf", w.overflow, 1);
    chk("t2_count", w.fifo_count, 16);
    sent_log.delete();
    n = 0;
    while (sent_log.size() < 16 && n < 600) begin step(); n++; end
    repeat (30) step();
    chk("t2_nsent", sent_log.size(), 16);
    for (int i = 0; i < 16 && i < sent_log.size(); i++) chk("t2_order", sent_log[i], 8'(i));
    // Round robin after a debug grant.
    do_reset();
    frame = 10;
    w.dbg_req = 1; w.dbg_data = 8'h5A;
    wait_start("t3_dbg0", 200, n);
    chk("t3_dbg0_data", w.tx_data, 8'h5A);
    chk("t3_dbg0_ack", w.dbg_ack, 1);
    step();
    ack_n = 0;
    sent_log.delete();
    for (int i = 0; i < 3; i++) begin
      w.push = 1; w.push_data = 8'h31 + 8'(i);
      step();
    end
    w.push = 0;
    w.dbg_req = 1; w.dbg_data = 8'hEE;
    n = 0;
    while (sent_log.size() < 4 && n < 300) begin step(); n++; end
    repeat (20) step();
    chk("t3_nsent", sent_log.size(), 4);
    if (sent_log.size() >= 4) begin
      chk("t3_b0", sent_log[0], 8'h31);
      chk("t3_b1", sent_log[1], 8'hEE);
      chk("t3_b2", sent_log[2], 8'h32);
      chk("t3_b3", sent_log[3], 8'h33);
    end
    chk("t3_acks", ack_n, 1);
    // Reset during WAIT_DONE with bytes queued.
    do_reset();
    frame = 30;
    w.push = 1; w.push_data = 8'h50;
    step();
    w.push = 0;
    wait_start("t5_first", 200, n);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      w.push = 1; w.push_data = 8'h60 + 8'(i);
      step();
    end
    w.push = 0;
    chk("t5_busy", w.tx_busy, 1);
    do_reset();
    chk("t5_count", w.fifo_count, 0);
    chk("t5_ovf", w.overflow, 0);
    chk("t5_empty", w.empty, 1);
    n = 0;
    while (w.tx_busy && n < 60) begin
      chk("t5_quiet", w.tx_start, 0);
      step();
      n++;
    end
    repeat (3) begin
      step();
      chk("t5_idle", w.tx_start, 0);
    end
    w.push = 1; w.push_data = 8'h77;
    step();
    w.push = 0;
    step();
    chk("t5_start", w.tx_start, 1);
    chk("t5_data", w.tx_data, 8'h77);
    // Sent counter wrap on a 2-bit instance.
    for (int i = 0; i < 3; i++) begin
      s.push = 1; s.push_data = 8'(i);
      step();
    end
    s.push = 0;
    repeat (30) step();
    chk("t6_sent3", s.sent_count, 3);
    s.push = 1; s.push_data = 8'h99;
    step();
    s.push = 0;
    repeat (12) step();
    chk("t6_wrap", s.sent_count, 0);
    chk("t6_empty", s.empty, 1);
    // Random traffic with varying load, frame lengths and occasional resets.
    foreach (sent_log[i]) sent_log[i] = 0;
    for (int ph = 0; ph < 3; ph++) begin
      int pp;
      pp = ph == 0 ? 10 : (ph == 1 ? 50 : 90);
      for (int c = 0; c < 1000; c++) begin
        w.push = $urandom_range(0, 99) < pp;
        w.push_data = 8'($urandom);
        if (!w.dbg_req && $urandom_range(0, 99) < 6) begin
          w.dbg_req = 1;
          w.dbg_data = 8'($urandom);
        end
        frame = $urandom_range(1, 8);
        rst = $urandom_range(0, 399) == 0;
        step();
      end
    end
    rst = 0; w.push = 0;
    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
